// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, ALU-op encodings and the ID control bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    reg_dst:    1'b0,
    alu_src:    1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    reg_write:  1'b0,
    branch:     1'b0,
    alu_op:     2'b00
  };

  // Instructions that read rt as a source operand rather than only writing it
  function automatic logic uses_rt(input logic [5:0] opcode);
    logic r;
    case (opcode)
      OP_RTYPE, OP_SW, OP_BEQ: r = 1'b1;
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/id_control_decode.sv
// Combinational opcode-to-control decoder for the ID stage; unknown opcodes decode as NOP.
module id_control_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  // Opcode to control bundle
  always_comb begin
    ctrl = CTRL_NOP;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_BRANCH;
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      default: ctrl = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: decode, writeback bypass, load-use stall, flush and
// the ID/EX pipeline register with saturating stall/flush event counters.
module id_stage
  import mips_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int CNTW = 16
) (
  input  logic            Clk,
  input  logic            reset,
  input  logic [31:0]     IfIdInstr,
  input  logic [DW-1:0]   IfIdPcPlus4,
  input  logic            IfIdValid,
  input  logic            Flush,
  output logic [AW-1:0]   ReadReg1,
  output logic [AW-1:0]   ReadReg2,
  input  logic [DW-1:0]   ReadData1,
  input  logic [DW-1:0]   ReadData2,
  input  logic            WbRegWrite,
  input  logic [AW-1:0]   WbWriteReg,
  input  logic [DW-1:0]   WbWriteData,
  output logic            Stall,
  output logic            IdExValid,
  output logic [DW-1:0]   IdExPcPlus4,
  output logic [DW-1:0]   IdExA,
  output logic [DW-1:0]   IdExB,
  output logic [DW-1:0]   IdExImm,
  output logic [AW-1:0]   IdExRs,
  output logic [AW-1:0]   IdExRt,
  output logic [AW-1:0]   IdExRd,
  output logic [5:0]      IdExFunct,
  output logic            IdExRegDst,
  output logic            IdExAluSrc,
  output logic            IdExMemRead,
  output logic            IdExMemWrite,
  output logic            IdExMemToReg,
  output logic            IdExRegWrite,
  output logic            IdExBranch,
  output logic [1:0]      IdExAluOp,
  output logic [CNTW-1:0] StallCount,
  output logic [CNTW-1:0] FlushCount
);

  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]   REG_ZERO = {AW{1'b0}};
  localparam logic [DW-1:0]   DATA_ZERO = {DW{1'b0}};

  logic [5:0]      opcode_s;
  logic [AW-1:0]   rs_s;
  logic [AW-1:0]   rt_s;
  logic [AW-1:0]   rd_s;
  logic [DW-1:0]   imm_s;
  ctrl_t           dec_ctrl_s;
  ctrl_t           ctrl_s;
  logic [DW-1:0]   opa_s;
  logic [DW-1:0]   opb_s;
  logic            uses_rt_s;
  logic            hazard_s;
  logic            stall_s;

  logic            idex_valid_r;
  logic [DW-1:0]   idex_pc_r;
  logic [DW-1:0]   idex_a_r;
  logic [DW-1:0]   idex_b_r;
  logic [DW-1:0]   idex_imm_r;
  logic [AW-1:0]   idex_rs_r;
  logic [AW-1:0]   idex_rt_r;
  logic [AW-1:0]   idex_rd_r;
  logic [5:0]      idex_funct_r;
  ctrl_t           idex_ctrl_r;
  logic [CNTW-1:0] stall_cnt_r;
  logic [CNTW-1:0] flush_cnt_r;

  // $0 reads as zero; a same-cycle writeback wins over the stale register-file value
  function automatic logic [DW-1:0] pick_operand(
    input logic [AW-1:0] addr,
    input logic [DW-1:0] rf_data,
    input logic          wb_we,
    input logic [AW-1:0] wb_addr,
    input logic [DW-1:0] wb_data
  );
    logic [DW-1:0] r;
    if (addr == REG_ZERO) begin
      r = DATA_ZERO;
    end else if (wb_we && (wb_addr == addr)) begin
      r = wb_data;
    end else begin
      r = rf_data;
    end
    return r;
  endfunction

  assign opcode_s = IfIdInstr[31:26];
  assign rs_s     = IfIdInstr[25:21];
  assign rt_s     = IfIdInstr[20:16];
  assign rd_s     = IfIdInstr[15:11];
  assign imm_s    = {{(DW-16){IfIdInstr[15]}}, IfIdInstr[15:0]};

  assign ReadReg1 = rs_s;
  assign ReadReg2 = rt_s;

  id_control_decode u_decode (
    .opcode (opcode_s),
    .ctrl   (dec_ctrl_s)
  );

  // An empty IF/ID slot must not carry any control side effects into EX
  always_comb begin
    if (IfIdValid) begin
      ctrl_s = dec_ctrl_s;
    end else begin
      ctrl_s = CTRL_NOP;
    end
  end

  assign opa_s = pick_operand(rs_s, ReadData1, WbRegWrite, WbWriteReg, WbWriteData);
  assign opb_s = pick_operand(rt_s, ReadData2, WbRegWrite, WbWriteReg, WbWriteData);

  assign uses_rt_s = uses_rt(opcode_s);
  assign hazard_s  = (idex_rt_r == rs_s) || (uses_rt_s && (idex_rt_r == rt_s));
  assign stall_s   = idex_valid_r && idex_ctrl_r.mem_read && (idex_rt_r != REG_ZERO) &&
                     IfIdValid && !Flush && hazard_s;
  assign Stall     = stall_s;

  // ID/EX pipeline register: bubble on flush or load-use stall, else the decoded instruction
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      idex_valid_r <= 1'b0;
      idex_pc_r    <= DATA_ZERO;
      idex_a_r     <= DATA_ZERO;
      idex_b_r     <= DATA_ZERO;
      idex_imm_r   <= DATA_ZERO;
      idex_rs_r    <= REG_ZERO;
      idex_rt_r    <= REG_ZERO;
      idex_rd_r    <= REG_ZERO;
      idex_funct_r <= 6'd0;
      idex_ctrl_r  <= CTRL_NOP;
    end else if (Flush || stall_s) begin
      idex_valid_r <= 1'b0;
      idex_pc_r    <= DATA_ZERO;
      idex_a_r     <= DATA_ZERO;
      idex_b_r     <= DATA_ZERO;
      idex_imm_r   <= DATA_ZERO;
      idex_rs_r    <= REG_ZERO;
      idex_rt_r    <= REG_ZERO;
      idex_rd_r    <= REG_ZERO;
      idex_funct_r <= 6'd0;
      idex_ctrl_r  <= CTRL_NOP;
    end else begin
      idex_valid_r <= IfIdValid;
      idex_pc_r    <= IfIdPcPlus4;
      idex_a_r     <= opa_s;
      idex_b_r     <= opb_s;
      idex_imm_r   <= imm_s;
      idex_rs_r    <= rs_s;
      idex_rt_r    <= rt_s;
      idex_rd_r    <= rd_s;
      idex_funct_r <= IfIdInstr[5:0];
      idex_ctrl_r  <= ctrl_s;
    end
  end

  // Saturating event counters; a flush only counts when it kills a real instruction
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= {CNTW{1'b0}};
      flush_cnt_r <= {CNTW{1'b0}};
    end else begin
      if (stall_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if (Flush && IfIdValid && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end
    end
  end

  assign IdExValid    = idex_valid_r;
  assign IdExPcPlus4  = idex_pc_r;
  assign IdExA        = idex_a_r;
  assign IdExB        = idex_b_r;
  assign IdExImm      = idex_imm_r;
  assign IdExRs       = idex_rs_r;
  assign IdExRt       = idex_rt_r;
  assign IdExRd       = idex_rd_r;
  assign IdExFunct    = idex_funct_r;
  assign IdExRegDst   = idex_ctrl_r.reg_dst;
  assign IdExAluSrc   = idex_ctrl_r.alu_src;
  assign IdExMemRead  = idex_ctrl_r.mem_read;
  assign IdExMemWrite = idex_ctrl_r.mem_write;
  assign IdExMemToReg = idex_ctrl_r.mem_to_reg;
  assign IdExRegWrite = idex_ctrl_r.reg_write;
  assign IdExBranch   = idex_ctrl_r.branch;
  assign IdExAluOp    = idex_ctrl_r.alu_op;
  assign StallCount   = stall_cnt_r;
  assign FlushCount   = flush_cnt_r;

endmodule
